codeword_serializer: RTL and testbench

CODEWORD_SERIALIZER -- requirements
Module: codeword_serializer

---
 rtl/codeword_serializer.sv | 170 +++++++++++++++++
 tb/tb_codeword_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codeword_serializer.sv
// Buffers Hamming codewords in a small FIFO and serializes each one, preceded by a sync
// preamble, one symbol per carrier period for the BPSK modulator.
module codeword_serializer #(
  parameter int unsigned                SAMPLE_NUMBER  = 256,
  parameter int unsigned                DATA_WIDTH     = 12,
  parameter int unsigned                PREAMBLE_WIDTH = 4,
  parameter logic [PREAMBLE_WIDTH-1:0]  PREAMBLE       = 4'b1010,
  parameter int unsigned                FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic                             en,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             bit_out,
  output logic                             bit_valid,
  output logic                             frame_start,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int unsigned CntW  = $clog2(SAMPLE_NUMBER);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned MaxW  = (DATA_WIDTH > PREAMBLE_WIDTH) ? DATA_WIDTH : PREAMBLE_WIDTH;
  localparam int unsigned IdxW  = $clog2(MaxW) + 1;

  typedef enum logic [1:0] {StIdle, StPreamble, StData} state_e;

  logic                      tick;
  logic                      push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]           level_q, level_d;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic [PREAMBLE_WIDTH-1:0] pre_q, pre_d;
  logic                      bit_q, bit_d;
  logic                      valid_q, valid_d;
  logic                      fs_q, fs_d;
  logic                      start_frame;

  // One tick per carrier period: the symbol boundary of the sine generator.
  assign tick       = en && (cnt_in == CntW'(SAMPLE_NUMBER - 1));
  assign s_ready    = (level_q < LvlW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    pre_d       = pre_q;
    bit_d       = bit_q;
    valid_d     = valid_q;
    fs_d        = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            bit_d   = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
      StPreamble: begin
        if (tick) begin
          if (idx_q == IdxW'(PREAMBLE_WIDTH - 1)) begin
            bit_d   = shreg_q[DATA_WIDTH-1];
            shreg_d = shreg_q << 1;
            idx_d   = '0;
            state_d = StData;
          end else begin
            bit_d = pre_q[PREAMBLE_WIDTH-1];
            pre_d = pre_q << 1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          // The last index branches out of the state, so idx never passes DATA_WIDTH-1.
          if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              bit_d   = 1'b0;
              valid_d = 1'b0;
              idx_d   = '0;
              state_d = StIdle;
            end
          end else begin
            bit_d   = shreg_q[DATA_WIDTH-1];
            shreg_d = shreg_q << 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (start_frame) begin
      pop     = 1'b1;
      shreg_d = mem_q[rd_ptr_q];
      pre_d   = PREAMBLE << 1;
      bit_d   = PREAMBLE[PREAMBLE_WIDTH-1];
      valid_d = 1'b1;
      fs_d    = 1'b1;
      idx_d   = '0;
      state_d = StPreamble;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shreg_q <= '0;
      pre_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign bit_out     = bit_q;
  assign bit_valid   = valid_q;
  assign frame_start = fs_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_codeword_serializer.sv
// Directed bench for codeword_serializer with SAMPLE_NUMBER=8, 12-bit words, preamble 1010.
module tb_codeword_serializer;

  logic        clk = 1'b0;
  logic        arstn = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  cnt_in;
  logic [11:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        frame_start;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Sine-generator sample counter model.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) cnt_in <= 3'd0;
    else if (en) cnt_in <= cnt_in + 3'd1;
  end

  codeword_serializer #(
    .SAMPLE_NUMBER (8),
    .DATA_WIDTH    (12),
    .PREAMBLE_WIDTH(4),
    .PREAMBLE      (4'b1010),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .en         (en),
    .cnt_in     (cnt_in),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .fifo_level (fifo_level)
  );

  task automatic push_word(input logic [11:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    arstn   = 1'b0;
    s_valid = 1'b0;
    en      = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_frame_start(input int budget, input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s wait: frame_start=%b after %0d cycles, required 1", name, frame_start, n);
    end
  endtask

  // Called at the negedge where frame_start is high; checks 16 symbols of 8 cycles each.
  task automatic check_frame(input logic [15:0] exp, input bit expect_next, input int stall_at,
                             input string name);
    logic bad;
    logic want;
    bad = 1'b0;
    for (int i = 0; i < 128; i++) begin
      want = exp[15 - i / 8];
      if (bit_out !== want || bit_valid !== 1'b1) bad = 1'b1;
      if (i == 1) begin
        checks++;
        if (frame_start !== 1'b0) begin
          errors++;
          $display("FAIL %s pulse: frame_start=%b in 2nd cycle, required 0", name, frame_start);
        end
      end
      if (i == stall_at) begin
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bit_out !== want || bit_valid !== 1'b1 || frame_start !== 1'b0) bad = 1'b1;
        end
        en = 1'b1;
      end
      if (i % 8 == 7) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s symbol %0d: bit_out=%b bit_valid=%b, required %b/1",
                   name, i / 8, bit_out, bit_valid, want);
        end
        bad = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (expect_next) begin
      if (frame_start !== 1'b1 || bit_valid !== 1'b1 || bit_out !== 1'b1) begin
        errors++;
        $display("FAIL %s next: frame_start=%b bit_valid=%b bit_out=%b, required 1/1/1",
                 name, frame_start, bit_valid, bit_out);
      end
    end else begin
      if (bit_valid !== 1'b0 || bit_out !== 1'b0 || fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL %s end: bit_valid=%b bit_out=%b fifo_level=%0d, required 0/0/0",
                 name, bit_valid, bit_out, fifo_level);
      end
    end
  endtask

  task automatic test_reset();
    arstn = 1'b1;
    #1 arstn = 1'b0;
    s_data  = 12'hFFF;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bit_out !== 1'b0 || bit_valid !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: bit_out=%b bit_valid=%b frame_start=%b, required 0/0/0",
               bit_out, bit_valid, frame_start);
    end
    checks++;
    if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset fifo: fifo_level=%0d s_ready=%b, required 0/1", fifo_level, s_ready);
    end
    s_valid = 1'b0;
    arstn   = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset no_push: fifo_level=%0d, required 0", fifo_level);
    end
  endtask

  task automatic test_single_frame();
    en = 1'b1;
    push_word(12'hA5C);
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL single level: fifo_level=%0d, required 1", fifo_level);
    end
    wait_frame_start(20, "single");
    checks++;
    if (cnt_in !== 3'd0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL single start: cnt_in=%0d fifo_level=%0d, required 0/0", cnt_in, fifo_level);
    end
    check_frame(16'hAA5C, 1'b0, -1, "single");
  endtask

  task automatic test_back_to_back();
    push_word(12'h001);
    push_word(12'hFFF);
    wait_frame_start(20, "b2b");
    check_frame(16'hA001, 1'b1, -1, "b2b_first");
    check_frame(16'hAFFF, 1'b0, -1, "b2b_second");
  endtask

  task automatic test_fill_full();
    en = 1'b0;
    push_word(12'h111);
    push_word(12'h222);
    push_word(12'h333);
    push_word(12'h444);
    checks++;
    if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full level: fifo_level=%0d s_ready=%b, required 4/0", fifo_level, s_ready);
    end
    s_data  = 12'h555;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full reject: fifo_level=%0d s_ready=%b, required 4/0", fifo_level, s_ready);
    end
    s_valid = 1'b0;
    en      = 1'b1;
    wait_frame_start(20, "full");
    check_frame(16'hA111, 1'b1, -1, "full_w1");
    check_frame(16'hA222, 1'b1, -1, "full_w2");
    check_frame(16'hA333, 1'b1, -1, "full_w3");
    check_frame(16'hA444, 1'b0, -1, "full_w4");
  endtask

  task automatic test_full_push_pop();
    en = 1'b0;
    push_word(12'hAAA);
    push_word(12'hBBB);
    push_word(12'hCCC);
    push_word(12'hDDD);
    s_data  = 12'hEEE;
    s_valid = 1'b1;
    en      = 1'b1;
    wait_frame_start(20, "pushpop");
    checks++;
    if (fifo_level !== 3'd3 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL pushpop pop_edge: fifo_level=%0d s_ready=%b, required 3/1",
               fifo_level, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL pushpop next: fifo_level=%0d s_ready=%b, required 4/0", fifo_level, s_ready);
    end
    do_reset();
  endtask

  task automatic test_en_stall();
    en = 1'b1;
    push_word(12'h5A3);
    wait_frame_start(20, "stall");
    check_frame(16'hA5A3, 1'b0, 51, "stall");
  endtask

  task automatic test_reset_midframe();
    logic bad;
    en = 1'b1;
    push_word(12'h111);
    push_word(12'h222);
    push_word(12'h333);
    wait_frame_start(20, "midrst");
    repeat (51) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd2 || bit_valid !== 1'b1 || bit_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst before: fifo_level=%0d bit_valid=%b bit_out=%b, required 2/1/0",
               fifo_level, bit_valid, bit_out);
    end
    arstn = 1'b0;
    #1;
    checks++;
    if (bit_valid !== 1'b0 || fifo_level !== 3'd0 || bit_out !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst async: bit_valid=%b fifo_level=%0d bit_out=%b s_ready=%b, req 0/0/0/1",
               bit_valid, fifo_level, bit_out, s_ready);
    end
    @(negedge clk);
    arstn = 1'b1;
    bad   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bit_valid !== 1'b0 || frame_start !== 1'b0 || fifo_level !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst quiet: bit_valid=%b frame_start=%b fifo_level=%0d, required 0/0/0",
               bit_valid, frame_start, fifo_level);
    end
    push_word(12'h0F0);
    wait_frame_start(20, "midrst_new");
    check_frame(16'hA0F0, 1'b0, -1, "midrst_new");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fill_full();
    test_full_push_pop();
    test_en_stall();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
